cg_enable_ctrl: RTL and testbench
=================================

CG_ENABLE_CTRL -- requirements
Module: cg_enable_ctrl

Interface
REQ-001 Parameter IDLE_TIMEOUT, default 8: consecutive idle ACTIVE cycles before the clock is gated; legal range 1..255.
REQ-002 Parameter WAKE_CYCLES, default 2: cycles spent in WAKE before requests are accepted; legal range 1..15.
REQ-003 Parameter STAT_W, default 16: width of the gated-cycle statistic counter.
REQ-004 clk  input  1  single block clock, rising-edge active, never gated internally.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  requester has work pending; held until accepted.
REQ-007 req_ready  output  1  block accepts work this cycle; transfer = req_valid && req_ready.
REQ-008 force_on  input  1  software override: keeps enable high and suppresses idle counting.
REQ-009 clr_stats  input  1  synchronous clear of gated_cycles.
REQ-010 enable  output  1  clock-gate enable for the downstream gated counter's enable port.
REQ-011 state_out  output  2  current FSM state: GATED=0, WAKE=1, ACTIVE=2.
REQ-012 gated_cycles  output  STAT_W  saturating count of cycles spent in GATED.

Function
REQ-013 FSM states shall be GATED, WAKE and ACTIVE, and all state, enable, req_ready and counters shall be registered.
REQ-014 GATED: enable=0, req_ready=0; req_valid=1 or force_on=1 at a rising edge -> WAKE on that edge.
REQ-015 WAKE: enable=1, req_ready=0; wake counter loads 0 on entry, increments each cycle, and state moves to ACTIVE after exactly WAKE_CYCLES cycles in WAKE.
REQ-016 ACTIVE: enable=1, req_ready=1; idle counter clears on every transfer and on every cycle force_on=1, otherwise increments.
REQ-017 ACTIVE -> GATED when idle counter equals IDLE_TIMEOUT-1 with no transfer and force_on=0, so enable falls after exactly IDLE_TIMEOUT consecutive idle cycles.
REQ-018 Simultaneous timeout and req_valid=1 in the same cycle: transfer wins, idle counter clears, state stays ACTIVE.
REQ-019 force_on asserted in WAKE shall not shorten WAKE.
REQ-020 force_on deasserted in ACTIVE restarts idle counting from 0.
REQ-021 enable shall be driven directly by a flip-flop, with no combinational decode at the output, to guarantee glitch-free gating.
REQ-022 enable shall rise one edge after the request edge in GATED, and req_ready shall rise WAKE_CYCLES edges later.
REQ-023 gated_cycles shall increment once per clk cycle while state is GATED and saturate at all-ones without wrap.
REQ-024 clr_stats=1 sets gated_cycles to 0 on the next edge and takes priority over increment in the same cycle.

Reset
REQ-025 rst=1 shall immediately force: state GATED, enable=0, req_ready=0, state_out=0, wake and idle counters 0, gated_cycles 0.
REQ-026 Reset asserted mid-WAKE or mid-ACTIVE shall abort without completing any transfer; after release the block restarts from GATED.
REQ-027 After rst deasserts, gated_cycles shall begin counting on the first rising edge.

Structure
REQ-028 Package cg_pkg shall hold the state enumeration (GATED/WAKE/ACTIVE, 2-bit) and default IDLE_TIMEOUT/WAKE_CYCLES constants.
REQ-029 One sub-module, cg_sat_counter (parameterised width, inc, clr, saturating), shall implement gated_cycles.
REQ-030 The FSM and the wake and idle counters shall remain in cg_enable_ctrl.

Verification
REQ-031 Reset release, req_valid=0 for 20 cycles -> enable=0, state_out=0, gated_cycles=20.
REQ-032 req_valid pulse held until accepted, defaults -> enable high 1 edge later, req_ready high 2 edges after that, then enable low after 8 idle cycles.
REQ-033 req_valid asserted on the 8th idle cycle of ACTIVE -> transfer accepted, state stays ACTIVE, idle count restarts at 0.
REQ-034 force_on=1 for 30 cycles with no requests -> enable stays 1; after release, enable falls exactly 8 cycles later.
REQ-035 STAT_W=4, stay GATED for 20 cycles -> gated_cycles saturates at 15; clr_stats pulse -> 0, then resumes counting.
REQ-036 rst asserted mid-WAKE -> enable and req_ready 0 immediately; after release the full WAKE_CYCLES latency repeats.

Source files
------------

// File: rtl/cg_pkg.sv
// Shared definitions for the clock-gate enable controller: state encoding and
// default timing constants.
package cg_pkg;

   typedef enum logic [1:0] {
      GATED  = 2'd0,
      WAKE   = 2'd1,
      ACTIVE = 2'd2
   } cg_state_e;

   localparam int DEF_IDLE_TIMEOUT = 8;
   localparam int DEF_WAKE_CYCLES  = 2;

endpackage

// File: rtl/cg_enable_ctrl_if.sv
// Request handshake between a requester and the clock-gate enable controller.
interface cg_enable_ctrl_if;

   logic req_valid;
   logic req_ready;

   modport master (output req_valid, input req_ready);
   modport slave  (input req_valid, output req_ready);

endinterface

// File: rtl/cg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module cg_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/cg_enable_ctrl.sv
// Clock-gate enable controller: wakes the downstream clock on request, gates it
// again after a run of idle cycles, and counts cycles spent gated.
module cg_enable_ctrl
   import cg_pkg::*;
#(
   parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
   parameter int WAKE_CYCLES  = DEF_WAKE_CYCLES,
   parameter int STAT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   cg_enable_ctrl_if.slave   bus,
   input  logic              force_on,
   input  logic              clr_stats,
   output logic              enable,
   output logic [1:0]        state_out,
   output logic [STAT_W-1:0] gated_cycles
);

   localparam logic [7:0] IDLE_LAST = 8'(IDLE_TIMEOUT - 1);
   localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

   cg_state_e  state_q, state_nxt;
   logic [3:0] wake_q, wake_nxt;
   logic [7:0] idle_q, idle_nxt;
   logic       enable_q;
   logic       ready_q;
   logic       xfer;

   assign xfer          = bus.req_valid && ready_q;
   assign bus.req_ready = ready_q;
   assign enable        = enable_q;
   assign state_out     = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= GATED;
         wake_q   <= '0;
         idle_q   <= '0;
         enable_q <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         wake_q   <= wake_nxt;
         idle_q   <= idle_nxt;
         // Enable and ready are decoded from the next state so the outputs
         // come straight from flops and line up with the state register.
         enable_q <= (state_nxt != GATED);
         ready_q  <= (state_nxt == ACTIVE);
      end
   end

   always_comb begin
      state_nxt = state_q;
      wake_nxt  = wake_q;
      idle_nxt  = idle_q;
      case (state_q)
         GATED: begin
            if (bus.req_valid || force_on) begin
               state_nxt = WAKE;
               wake_nxt  = '0;
            end
         end
         WAKE: begin
            if (wake_q == WAKE_LAST) begin
               state_nxt = ACTIVE;
               idle_nxt  = '0;
            end else begin
               wake_nxt = wake_q + 4'd1;
            end
         end
         ACTIVE: begin
            // A transfer on the timeout cycle keeps the block awake.
            if (xfer || force_on) begin
               idle_nxt = '0;
            end else if (idle_q == IDLE_LAST) begin
               state_nxt = GATED;
               idle_nxt  = '0;
            end else begin
               idle_nxt = idle_q + 8'd1;
            end
         end
         default: begin
            state_nxt = GATED;
            wake_nxt  = '0;
            idle_nxt  = '0;
         end
      endcase
   end

   cg_sat_counter #(
      .W (STAT_W)
   ) u_gated_cnt (
      .clk (clk),
      .rst (rst),
      .inc (state_q == GATED),
      .clr (clr_stats),
      .cnt (gated_cycles)
   );

endmodule

// File: tb/tb_cg_enable_ctrl.sv
// Directed bench for cg_enable_ctrl: a per-cycle vector table for the default
// build plus hand sequences for saturation (STAT_W=4) and mid-flight reset.
module tb_cg_enable_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        force_on = 1'b0;
   logic        clr_stats = 1'b0;
   logic        enable;
   logic [1:0]  state_out;
   logic [15:0] gated_cycles;

   logic        force4 = 1'b0;
   logic        clr4 = 1'b0;
   logic        enable4;
   logic [1:0]  state4;
   logic [3:0]  gated4;

   int tests = 0;
   int fails = 0;

   cg_enable_ctrl_if bus ();
   cg_enable_ctrl_if bus4 ();

   cg_enable_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .force_on     (force_on),
      .clr_stats    (clr_stats),
      .enable       (enable),
      .state_out    (state_out),
      .gated_cycles (gated_cycles)
   );

   cg_enable_ctrl #(.STAT_W(4)) dut4 (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus4),
      .force_on     (force4),
      .clr_stats    (clr4),
      .enable       (enable4),
      .state_out    (state4),
      .gated_cycles (gated4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rv;
      logic       fo;
      logic       clr;
      logic       en;
      logic       rdy;
      logic [1:0] st;
      int         g;
   } vec_t;

   vec_t tab[$];

   task automatic add(input logic rv, input logic fo, input logic clr,
                      input logic en, input logic rdy, input logic [1:0] st,
                      input int g);
      vec_t v;
      v.rv = rv; v.fo = fo; v.clr = clr;
      v.en = en; v.rdy = rdy; v.st = st; v.g = g;
      tab.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_main(input string tag, input int en, input int rdy,
                           input int st, input int g);
      chk({tag, " enable"}, int'(enable), en);
      chk({tag, " req_ready"}, int'(bus.req_ready), rdy);
      chk({tag, " state_out"}, int'(state_out), st);
      chk({tag, " gated_cycles"}, int'(gated_cycles), g);
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus4.req_valid = 1'b0;

      // Reset release, 20 idle cycles
      for (int i = 0; i < 20; i++) add(0, 0, 0, 0, 0, 0, i + 1);
      // Request held until accepted, then 8 idle cycles to gate
      add(1, 0, 0, 1, 0, 1, 21);
      add(1, 0, 0, 1, 0, 1, 21);
      add(1, 0, 0, 1, 1, 2, 21);
      add(1, 0, 0, 1, 1, 2, 21);
      for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 1, 2, 21);
      add(0, 0, 0, 0, 0, 0, 21);
      add(0, 0, 0, 0, 0, 0, 22);
      // Request on the 8th idle cycle wins over the timeout
      add(1, 0, 0, 1, 0, 1, 23);
      add(1, 0, 0, 1, 0, 1, 23);
      add(1, 0, 0, 1, 1, 2, 23);
      add(1, 0, 0, 1, 1, 2, 23);
      for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 1, 2, 23);
      add(1, 0, 0, 1, 1, 2, 23);
      for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 1, 2, 23);
      add(0, 0, 0, 0, 0, 0, 23);
      add(0, 0, 0, 0, 0, 0, 24);
      // force_on for 30 cycles, WAKE not shortened, then 8 cycles to gate
      add(0, 1, 0, 1, 0, 1, 25);
      add(0, 1, 0, 1, 0, 1, 25);
      add(0, 1, 0, 1, 1, 2, 25);
      for (int i = 0; i < 27; i++) add(0, 1, 0, 1, 1, 2, 25);
      for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 1, 2, 25);
      add(0, 0, 0, 0, 0, 0, 25);
      add(0, 0, 0, 0, 0, 0, 26);
      // Statistic clear, then counting resumes
      add(0, 0, 1, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 2);

      tick();
      tick();
      chk_main("reset", 0, 0, 0, 0);
      chk("reset gated4", int'(gated4), 0);
      rst = 1'b0;

      for (int i = 0; i < tab.size(); i++) begin
         bus.req_valid = tab[i].rv;
         force_on      = tab[i].fo;
         clr_stats     = tab[i].clr;
         tick();
         chk_main($sformatf("vec%0d", i), int'(tab[i].en), int'(tab[i].rdy),
                  int'(tab[i].st), tab[i].g);
      end
      bus.req_valid = 1'b0;
      clr_stats     = 1'b0;

      // Narrow statistic: saturates without wrap, clear, resume
      chk("sat4 at 15", int'(gated4), 15);
      chk("sat4 state", int'(state4), 0);
      repeat (5) tick();
      chk("sat4 hold", int'(gated4), 15);
      clr4 = 1'b1;
      tick();
      chk("sat4 clr", int'(gated4), 0);
      clr4 = 1'b0;
      tick();
      chk("sat4 resume1", int'(gated4), 1);
      tick();
      chk("sat4 resume2", int'(gated4), 2);

      // Reset mid-WAKE: outputs drop immediately, full wake latency repeats
      bus.req_valid = 1'b1;
      tick();
      chk("pre-rst wake state", int'(state_out), 1);
      chk("pre-rst wake enable", int'(enable), 1);
      #2 rst = 1'b1;
      #1;
      chk_main("rst in wake", 0, 0, 0, 0);
      tick();
      chk_main("rst held", 0, 0, 0, 0);
      rst = 1'b0;
      tick();
      chk_main("rewake1", 1, 0, 1, 1);
      tick();
      chk_main("rewake2", 1, 0, 1, 1);
      tick();
      chk_main("reactive", 1, 1, 2, 1);

      // Reset mid-ACTIVE with request pending: no transfer, back to GATED
      #2 rst = 1'b1;
      #1;
      chk_main("rst in active", 0, 0, 0, 0);
      bus.req_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk_main("post-rst gated", 0, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
